// File: rtl/pio_edge_irq_param.sv
// Avalon-MM input port: per-bit synchroniser, debounce filter and edge capture,
// with separate rise/fall enables and a maskable level interrupt.

module pio_edge_irq_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int DBNC_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pin_i,
    input  logic [DBNC_W-1:0] dbnc_i,
    input  logic              rise_en_i,
    input  logic              fall_en_i,
    input  logic              clr_i,
    output logic              sync_o,
    output logic              filt_o,
    output logic              cap_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DBNC_W-1:0]      cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   filt_dly_q;
    logic                   cap_q, cap_d;
    logic                   rise, fall;

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign filt_o = filt_q;
    assign cap_o  = cap_q;

    assign rise = filt_q & ~filt_dly_q & rise_en_i;
    assign fall = ~filt_q & filt_dly_q & fall_en_i;

    // A counter left above a newly lowered threshold simply wraps round to it.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync_o == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == dbnc_i) begin
            filt_d = sync_o;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + DBNC_W'(1);
        end
    end

    // Set has priority over a same-cycle W1C so no edge is lost.
    always_comb begin
        cap_d = cap_q;
        if (rise | fall)
            cap_d = 1'b1;
        else if (clr_i)
            cap_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            filt_q     <= 1'b0;
            filt_dly_q <= 1'b0;
            cap_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pin_i};
            cnt_q      <= cnt_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            cap_q      <= cap_d;
        end
    end
endmodule

module pio_edge_irq_param #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DBNC_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq,
    output logic [31:0]      readdata
);
    logic [WIDTH-1:0]  rise_en_q, fall_en_q, mask_q;
    logic [DBNC_W-1:0] dbnc_q;
    logic [WIDTH-1:0]  sync, filt, cap;
    logic [31:0]       rd_d;
    logic              wr_en;

    assign wr_en = chipselect & ~write_n;
    assign irq   = |(cap & mask_q);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        pio_edge_irq_lane #(
            .SYNC_STAGES(SYNC_STAGES),
            .DBNC_W     (DBNC_W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .pin_i    (in_port[i]),
            .dbnc_i   (dbnc_q),
            .rise_en_i(rise_en_q[i]),
            .fall_en_i(fall_en_q[i]),
            .clr_i    (wr_en && (address == 3'd3) && writedata[i]),
            .sync_o   (sync[i]),
            .filt_o   (filt[i]),
            .cap_o    (cap[i])
        );
    end

    always_comb begin
        rd_d = '0;
        case (address)
            3'd0:    rd_d = 32'(filt);
            3'd1:    rd_d = 32'(rise_en_q);
            3'd2:    rd_d = 32'(mask_q);
            3'd3:    rd_d = 32'(cap);
            3'd4:    rd_d = 32'(fall_en_q);
            3'd5:    rd_d = 32'(dbnc_q);
            3'd6:    rd_d = 32'(sync);
            default: rd_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_en_q <= '1;
            fall_en_q <= '1;
            mask_q    <= '0;
            dbnc_q    <= '0;
            readdata  <= '0;
        end else begin
            readdata <= rd_d;
            if (wr_en) begin
                case (address)
                    3'd1:    rise_en_q <= writedata[WIDTH-1:0];
                    3'd2:    mask_q    <= writedata[WIDTH-1:0];
                    3'd4:    fall_en_q <= writedata[WIDTH-1:0];
                    3'd5:    dbnc_q    <= writedata[DBNC_W-1:0];
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pio_edge_irq_param.sv
// Bench for pio_edge_irq_param: register-read scoreboard, reset-value table and
// hand-written sequences for debounce, set/clear collision, mask and reset abort.

module tb_pio_edge_irq_param;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic        irq;
    logic [31:0] readdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] exp;
    } vec_t;

    vec_t        rst_tbl[8];
    logic [31:0] exp_q[$];

    pio_edge_irq_param #(.WIDTH(8), .SYNC_STAGES(2), .DBNC_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .irq       (irq),
        .readdata  (readdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected value is queued when the address is driven, compared when readdata updates.
    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        logic [31:0] e;
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        exp_q.push_back(exp);
        tick();
        chipselect = 1'b0;
        e = exp_q.pop_front();
        chk($sformatf("%s rd[%0d]", name, a), readdata, e);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic watch_data3(input int n, output logic seen);
        seen    = 1'b0;
        address = 3'd0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (readdata[3]) seen = 1'b1;
        end
    endtask

    initial begin
        logic seen;
        rst_tbl[0] = '{3'd0, 32'h00};
        rst_tbl[1] = '{3'd1, 32'hFF};
        rst_tbl[2] = '{3'd2, 32'h00};
        rst_tbl[3] = '{3'd3, 32'h00};
        rst_tbl[4] = '{3'd4, 32'hFF};
        rst_tbl[5] = '{3'd5, 32'h00};
        rst_tbl[6] = '{3'd6, 32'h00};
        rst_tbl[7] = '{3'd7, 32'h00};

        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        repeat (3) tick();
        chk("irq in reset", 32'(irq), 32'h0);
        chk("readdata in reset", readdata, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) rd(rst_tbl[i].addr, rst_tbl[i].exp, "reset");
        chk("irq after reset", 32'(irq), 32'h0);

        // Rise on bit 0 reaches irq after the 4th edge; fall not enabled.
        wr(3'd2, 32'h01); wr(3'd4, 32'h00); wr(3'd5, 32'h00);
        rd(3'd4, 32'h00, "fall_en wr");
        in_port[0] = 1'b1;
        repeat (3) tick();
        chk("irq before 4th edge", 32'(irq), 32'h0);
        tick();
        chk("irq at 4th edge", 32'(irq), 32'h1);
        rd(3'd3, 32'h01, "rise cap");
        in_port[0] = 1'b0;
        repeat (6) tick();
        rd(3'd3, 32'h01, "no fall cap");
        rd(3'd0, 32'h00, "data after fall");
        wr(3'd3, 32'h01);
        chk("irq after w1c", 32'(irq), 32'h0);

        // Debounce: 5-cycle pulse suppressed, 6-cycle pulse passes.
        wr(3'd4, 32'hFF); wr(3'd5, 32'h05);
        rd(3'd5, 32'h05, "dbnc wr");
        in_port[3] = 1'b1; repeat (5) tick(); in_port[3] = 1'b0;
        watch_data3(20, seen);
        chk("glitch5 data seen", 32'(seen), 32'h0);
        rd(3'd3, 32'h00, "glitch5 cap");
        in_port[3] = 1'b1; repeat (6) tick(); in_port[3] = 1'b0;
        watch_data3(20, seen);
        chk("pulse6 data seen", 32'(seen), 32'h1);
        rd(3'd3, 32'h08, "pulse6 cap");
        chk("pulse6 irq masked", 32'(irq), 32'h0);
        wr(3'd3, 32'hFF);

        // Set/clear collision on bit 2.
        wr(3'd5, 32'h00); wr(3'd2, 32'h04);
        in_port[2] = 1'b1; repeat (5) tick();
        chk("bit2 rise irq", 32'(irq), 32'h1);
        in_port[2] = 1'b0;
        repeat (3) tick();
        wr(3'd3, 32'h04);
        chk("collision irq", 32'(irq), 32'h1);
        rd(3'd3, 32'h04, "collision cap");
        wr(3'd3, 32'h04);
        chk("second w1c irq", 32'(irq), 32'h0);
        rd(3'd3, 32'h00, "second w1c cap");

        // Capture while masked, then unmask.
        wr(3'd2, 32'h00);
        in_port[7] = 1'b1; repeat (6) tick();
        chk("masked irq", 32'(irq), 32'h0);
        rd(3'd3, 32'h80, "masked cap");
        rd(3'd0, 32'h80, "data bit7");
        rd(3'd6, 32'h80, "raw bit7");
        rd(3'd7, 32'h00, "reserved");
        wr(3'd2, 32'h80);
        chk("unmask irq", 32'(irq), 32'h1);

        // Reset during a debounce count in progress.
        wr(3'd3, 32'hFF); wr(3'd5, 32'd10);
        in_port = 8'h82;
        repeat (5) tick();
        reset = 1'b1; in_port = 8'h00;
        repeat (3) tick();
        chk("irq mid-dbnc reset", 32'(irq), 32'h0);
        chk("readdata mid-dbnc reset", readdata, 32'h0);
        reset = 1'b0;
        repeat (20) tick();
        chk("irq after abort", 32'(irq), 32'h0);
        for (int i = 0; i < 8; i++) rd(rst_tbl[i].addr, rst_tbl[i].exp, "re-reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected $finish");
        $fatal(1, "timeout");
    end
endmodule
